// File: rtl/xbar_pkg.sv
// Shared crossbar types: master IDs, FIFO occupancy states and command encoding.
package xbar_pkg;

    typedef logic [2:0] master_id_t;

    localparam master_id_t MID_NONE = 3'd0;
    localparam master_id_t MID_M1   = 3'd1;
    localparam master_id_t MID_M2   = 3'd2;
    localparam master_id_t MID_M3   = 3'd3;
    localparam master_id_t MID_M4   = 3'd4;

    localparam int NUM_MASTERS = 4;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occ_state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // True for IDs that name a real master (1..4).
    function automatic logic mid_valid(master_id_t id);
        return (id >= MID_M1) && (id <= MID_M4);
    endfunction

endpackage

// File: rtl/id_fifo.sv
// Issue-order ID FIFO. No bypass and no overflow guard: the caller qualifies
// push/pop against full/empty.
module id_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wptr;
    logic [AW-1:0]               rptr;

    // Storage, pointers (wrap modulo DEPTH) and occupancy count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/resp_router_4.sv
// Slave-side read-response router: tracks the owner of each accepted read in
// issue order and steers each slave response back to that master.
module resp_router_4
    import xbar_pkg::*;
#(
    parameter int SLAVE      = 0,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  slave_req,
    input  logic                  slave_ack,
    input  logic                  slave_cmd,
    input  logic [2:0]            number_master_en,
    input  logic                  slave_resp,
    input  logic [DATA_WIDTH-1:0] slave_rdata,
    output logic                  master_1_resp,
    output logic                  master_2_resp,
    output logic                  master_3_resp,
    output logic                  master_4_resp,
    output logic [DATA_WIDTH-1:0] master_1_rdata,
    output logic [DATA_WIDTH-1:0] master_2_rdata,
    output logic [DATA_WIDTH-1:0] master_3_rdata,
    output logic [DATA_WIDTH-1:0] master_4_rdata,
    output logic                  rd_accept_ok,
    output logic                  err_resp,
    output logic                  err_id
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                                   rd_acc;
    logic                                   id_ok;
    logic                                   push;
    logic                                   pop;
    logic                                   full;
    logic                                   empty;
    logic [CW-1:0]                          count;
    master_id_t                             head;
    master_id_t                             lane_sel;
    logic [NUM_MASTERS-1:0]                 resp_q;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] rdata_q;
    occ_state_e                             state;
    occ_state_e                             state_nxt;

    assign rd_acc   = slave_req && slave_ack && (slave_cmd == CMD_READ);
    assign id_ok    = mid_valid(number_master_en);
    // A pop frees the slot, so a push while full is fine in the same cycle.
    assign pop      = slave_resp && !empty;
    assign push     = rd_acc && id_ok && (!full || pop);
    assign lane_sel = head - MID_M1;

    id_fifo #(
        .WIDTH ($bits(master_id_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (number_master_en),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Per-master registered response pulse and held read data.
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                resp_q[i]  <= 1'b0;
                rdata_q[i] <= '0;
            end else begin
                resp_q[i] <= pop && (lane_sel == master_id_t'(i));
                if (pop && (lane_sel == master_id_t'(i)))
                    rdata_q[i] <= slave_rdata;
            end
        end
    end

    assign master_1_resp  = resp_q[0];
    assign master_2_resp  = resp_q[1];
    assign master_3_resp  = resp_q[2];
    assign master_4_resp  = resp_q[3];
    assign master_1_rdata = rdata_q[0];
    assign master_2_rdata = rdata_q[1];
    assign master_3_rdata = rdata_q[2];
    assign master_4_rdata = rdata_q[3];

    assign rd_accept_ok = !full;

    // Sticky error flags: orphan response, bad ID, or dropped push while full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_resp <= 1'b0;
            err_id   <= 1'b0;
        end else begin
            if (slave_resp && empty)
                err_resp <= 1'b1;
            if (rd_acc && (!id_ok || (full && !pop)))
                err_id <= 1'b1;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= EMPTY;
        else          state <= state_nxt;
    end

    // Occupancy next-state from push/pop and current count.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (push) state_nxt = PARTIAL;
            PARTIAL: begin
                if (push && !pop && (count == CW'(DEPTH - 1)))
                    state_nxt = FULL;
                else if (pop && !push && (count == CW'(1)))
                    state_nxt = EMPTY;
            end
            FULL:    if (pop && !push) state_nxt = PARTIAL;
            default: state_nxt = EMPTY;
        endcase
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(rd_acc && id_ok && full && !pop))
        else $error("resp_router_4[%0d]: read accepted while full", SLAVE);

    a_occ_match: assert property (@(posedge clk) disable iff (!reset_n)
        (state == EMPTY) == empty && (state == FULL) == full)
        else $error("resp_router_4[%0d]: occupancy state mismatch", SLAVE);

endmodule

// File: tb/tb_resp_router_4.sv
// Directed bench for resp_router_4 with a response scoreboard.
module tb_resp_router_4;

    localparam int DW = 32;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          slave_req = 1'b0;
    logic          slave_ack = 1'b0;
    logic          slave_cmd = 1'b0;
    logic [2:0]    number_master_en = 3'd0;
    logic          slave_resp = 1'b0;
    logic [DW-1:0] slave_rdata = '0;
    logic          m1_resp, m2_resp, m3_resp, m4_resp;
    logic [DW-1:0] m1_rdata, m2_rdata, m3_rdata, m4_rdata;
    logic          rd_accept_ok, err_resp, err_id;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t q[$];

    resp_router_4 #(.SLAVE(0), .DATA_WIDTH(DW), .DEPTH(4)) u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .slave_req        (slave_req),
        .slave_ack        (slave_ack),
        .slave_cmd        (slave_cmd),
        .number_master_en (number_master_en),
        .slave_resp       (slave_resp),
        .slave_rdata      (slave_rdata),
        .master_1_resp    (m1_resp),
        .master_2_resp    (m2_resp),
        .master_3_resp    (m3_resp),
        .master_4_resp    (m4_resp),
        .master_1_rdata   (m1_rdata),
        .master_2_rdata   (m2_rdata),
        .master_3_rdata   (m3_rdata),
        .master_4_rdata   (m4_rdata),
        .rd_accept_ok     (rd_accept_ok),
        .err_resp         (err_resp),
        .err_id           (err_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One stimulus cycle: drive, let one rising edge capture it, then go idle.
    task automatic step(input logic req, input logic ack, input logic cmd,
                        input logic [2:0] mid, input logic resp, input logic [31:0] rd);
        slave_req = req; slave_ack = ack; slave_cmd = cmd;
        number_master_en = mid; slave_resp = resp; slave_rdata = rd;
        @(posedge clk); #1;
        slave_req = 0; slave_ack = 0; slave_cmd = 0;
        number_master_en = 0; slave_resp = 0; slave_rdata = '0;
    endtask

    task automatic rd(input logic [2:0] mid);
        step(1, 1, 0, mid, 0, '0);
    endtask

    task automatic expect_resp(input int id, input logic [31:0] d);
        q.push_back('{id: id, data: d, cyc: cyc + 1});
    endtask

    task automatic resp(input int id, input logic [31:0] d);
        expect_resp(id, d);
        step(0, 0, 0, 3'd0, 1, d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_resp"}, {28'd0, m4_resp, m3_resp, m2_resp, m1_resp}, 32'd0);
        chk({nm, "_rd1"}, m1_rdata, 32'd0);
        chk({nm, "_rd2"}, m2_rdata, 32'd0);
        chk({nm, "_rd3"}, m3_rdata, 32'd0);
        chk({nm, "_rd4"}, m4_rdata, 32'd0);
    endtask

    // Monitor: every master response pops the scoreboard and is compared.
    always @(negedge clk) begin
        if (reset_n) begin
            logic [3:0]  r;
            logic [31:0] d [4];
            r = {m4_resp, m3_resp, m2_resp, m1_resp};
            d[0] = m1_rdata; d[1] = m2_rdata; d[2] = m3_rdata; d[3] = m4_rdata;
            if ($countones(r) > 1) begin
                tests++; fails++;
                $display("FAIL onehot: got %b want at most one", r);
            end
            for (int i = 0; i < 4; i++) begin
                if (r[i]) begin
                    if (q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_resp: got master %0d want none", i + 1);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("resp_id", i + 1, e.id);
                        chk("resp_data", d[i], e.data);
                        chk("resp_cyc", cyc, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        @(posedge clk); #1;
        chk_all_zero("rst");
        chk("rst_ok", rd_accept_ok, 1);
        chk("rst_err_resp", err_resp, 0);
        chk("rst_err_id", err_id, 0);
        reset_n = 1'b1;
        idle(1);

        // 1: one read per master, responses return in order
        rd(3'd1); rd(3'd2); rd(3'd3); rd(3'd4);
        chk("t1_full", rd_accept_ok, 0);
        resp(1, 32'hA1); resp(2, 32'hB2); resp(3, 32'hC3); resp(4, 32'hD4);
        idle(1);
        chk("t1_ok", rd_accept_ok, 1);
        chk("t1_err_resp", err_resp, 0);
        chk("t1_err_id", err_id, 0);

        // 2: fill with master 2, then push+pop while full
        rd(3'd2); rd(3'd2); rd(3'd2);
        chk("t2_ok3", rd_accept_ok, 1);
        rd(3'd2);
        chk("t2_full", rd_accept_ok, 0);
        expect_resp(2, 32'h2222_0001);
        step(1, 1, 0, 3'd2, 1, 32'h2222_0001);
        chk("t2_still_full", rd_accept_ok, 0);
        chk("t2_err_id", err_id, 0);
        resp(2, 32'h2222_0002); resp(2, 32'h2222_0003);
        resp(2, 32'h2222_0004); resp(2, 32'h2222_0005);
        idle(1);
        chk("t2_drained", rd_accept_ok, 1);
        chk("t2_err_resp", err_resp, 0);

        // 3: write ack is not tracked; following response is orphaned
        step(1, 1, 1, 3'd3, 0, '0);
        chk("t3_ok", rd_accept_ok, 1);
        step(0, 0, 0, 3'd0, 1, 32'h33);
        chk("t3_err_resp", err_resp, 1);
        idle(3);
        chk("t3_err_sticky", err_resp, 1);
        chk("t3_err_id", err_id, 0);

        // 4: long idle, then back-to-back responses; other rdata holds
        rd(3'd3); rd(3'd1);
        idle(20);
        resp(3, 32'h3333_0003);
        resp(1, 32'h1111_0001);
        chk("t4_m3_hold", m3_rdata, 32'h3333_0003);
        chk("t4_m1_data", m1_rdata, 32'h1111_0001);
        chk("t4_m2_hold", m2_rdata, 32'h2222_0005);
        idle(2);

        // 5: asynchronous reset mid-cycle with reads outstanding
        rd(3'd1); rd(3'd2); rd(3'd4);
        #3 reset_n = 1'b0;
        #1;
        chk_all_zero("t5");
        chk("t5_ok", rd_accept_ok, 1);
        chk("t5_err_resp", err_resp, 0);
        chk("t5_err_id", err_id, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        step(0, 0, 0, 3'd0, 1, 32'h55);
        chk("t5_orphan", err_resp, 1);
        idle(2);

        // 6: read with no master granted
        step(1, 1, 0, 3'd0, 0, '0);
        chk("t6_err_id", err_id, 1);
        chk("t6_count", 32'(u_dut.u_fifo.count), 0);
        chk("t6_ok", rd_accept_ok, 1);
        idle(3);

        // Every expected response must have been seen
        begin
            int waited = 0;
            while (q.size() != 0 && waited < 10) begin idle(1); waited++; end
        end
        chk("sb_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/resp_router_4.md
Name: resp_router_4

Overview:
- Slave-side read-response return path for the 4-master crossbar, one instance per slave port.
- Records which master owns each accepted read on that slave, in issue order.
- Routes each later slave read response (slave_resp + slave_rdata) back to the owning master.
- Supplies a backpressure flag that the crossbar uses to gate slave_req when no more reads can be tracked.

Parameters:
SLAVE, 0, slave index 0..3 served by this instance (debug/assertion tagging only).
DATA_WIDTH, 32, read data width.
DEPTH, 4, outstanding reads tracked; power of 2, 2..16.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
slave_req  input  1  request to slave (arbiter output)
slave_ack  input  1  slave accepts current request this cycle
slave_cmd  input  1  command of granted request: 0 = read, 1 = write
number_master_en  input  3  granted master: 1..4 = master_1..4, 0 = none
slave_resp  input  1  one-cycle pulse, read data valid from slave
slave_rdata  input  DATA_WIDTH  read data from slave
master_1_resp .. master_4_resp  output  1 each  read response pulse to the master
master_1_rdata .. master_4_rdata  output  DATA_WIDTH each  read data to the master
rd_accept_ok  output  1  high when a read may be issued (tracking FIFO not full)
err_resp  output  1  sticky: response arrived with nothing outstanding
err_id  output  1  sticky: read accepted with number_master_en outside 1..4

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous, active-low on reset_n; all state clears immediately.
- Reset values:
  - FIFO empty; pointers and count 0.
  - All master_n_resp = 0; all master_n_rdata = 0.
  - rd_accept_ok = 1; err_resp = 0; err_id = 0.
- Push: on a cycle with slave_req && slave_ack && !slave_cmd:
  - number_master_en is written into the ID FIFO.
  - Writes (slave_cmd = 1) are never pushed; the write ack is routed elsewhere.
  - If number_master_en is 0 or >4: no push, err_id set.
- Pop and route: on a cycle with slave_resp && FIFO not empty:
  - The head ID is popped.
  - In the next cycle exactly one master_n_resp = 1, n = popped ID, and that master's master_n_rdata = the registered slave_rdata.
  - Latency is exactly 1 clk from slave_resp to master_n_resp; outputs are registered.
- master_n_rdata holds its last value until the next response to that master; the other masters' rdata is unchanged.
- master_n_resp is high for one cycle per slave_resp pulse; back-to-back slave_resp pulses give back-to-back master responses, in FIFO order.
- Simultaneous push and pop:
  - Both happen; count is unchanged.
  - The pop uses the old head, and the pushed ID goes to the tail.
  - This is legal when full: a pop and push in the same cycle do not overflow.
- Empty + slave_resp: no bypass of a same-cycle push; the response cannot belong to a request accepted in the same cycle. No master_n_resp; err_resp set; data dropped.
- Full: rd_accept_ok = 0 when count == DEPTH, combinationally from count.
- Push while full without a simultaneous pop is a protocol violation:
  - The push is dropped and err_id is set.
  - The assertion fires.
- Count is $clog2(DEPTH)+1 bits. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Reset asserted mid-operation: outstanding IDs are discarded. Any in-flight response after reset release sets err_resp.
- Error flags are sticky until reset.
- FSM per FIFO occupancy, for coverage and assertion use: EMPTY, PARTIAL, FULL.
  - EMPTY -> PARTIAL on push without pop.
  - PARTIAL -> FULL when count reaches DEPTH.
  - FULL -> PARTIAL on pop without push.
  - PARTIAL -> EMPTY when count reaches 0.
  - Push+pop holds the state; in EMPTY a pop is impossible, so push+resp moves to PARTIAL and sets err_resp.

Decomposition:
- Package xbar_pkg holds:
  - typedef master_id_t (logic [2:0]);
  - constants MID_NONE = 0, MID_M1..MID_M4 = 1..4;
  - typedef occ_state_e {EMPTY, PARTIAL, FULL};
  - CMD_READ = 0, CMD_WRITE = 1.
- The round-robin arbiter is also to import master_id_t from xbar_pkg.
- One sub-module is natural: id_fifo (parameters WIDTH and DEPTH; push/pop/full/empty/count; no internal bypass).
- Response demux and error logic sit in resp_router_4.

Test Plan:
1. Reads issued by masters 1, 2, 3, 4 (slave_ack each cycle, cmd = 0), then 4 slave_resp pulses with rdata A1, B2, C3, D4 -> master_1..4_resp pulse in order, 1 cycle after each pulse, with rdata A1, B2, C3, D4; err flags 0.
2. DEPTH = 4: 4 reads from master 2, no resp -> rd_accept_ok = 0 after the 4th ack. Fifth accepted read with a same-cycle slave_resp -> pop and push both occur, master_2_resp = 1, rd_accept_ok stays 0.
3. Write ack (cmd = 1, master 3) with no read outstanding, then slave_resp -> no master_n_resp, err_resp = 1 and stays 1.
4. Reads from masters 3, 1 accepted, then 20 cycles idle, then 2 slave_resp pulses on consecutive cycles -> master_3_resp then master_1_resp on consecutive cycles; master_3_rdata is unchanged when master_1 responds.
5. 3 reads outstanding, reset_n asserted low asynchronously mid-cycle -> all outputs 0 and rd_accept_ok = 1 immediately. A later slave_resp -> err_resp = 1, no master response.
6. Read acked with number_master_en = 0 -> no push, err_id = 1, FIFO count 0.
